sram_mem_ctrl: RTL

//  Memory-stage controller between the EXE/MEM pipeline register and the MEM/WB register.

---
 rtl/sram_mem_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits one 32-bit load/store into two 16-bit accesses
// on an external asynchronous SRAM, holding ready low while the access runs.
module sram_mem_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int ACC_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wr_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int CNT_W = $clog2(ACC_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;

  logic [31:0] offset;
  logic [30:0] half_addr;
  logic        in_phase;
  logic        dq_oe;
  logic [15:0] dq_out;

  // Halfword address: word index k doubled, plus 1 while the high half is in flight.
  assign offset    = addr - 32'(BASE_ADDR);
  assign half_addr = {offset[31:2], state == HI};
  assign SRAM_ADDR = half_addr[SRAM_ADDR_W-1:0];

  // Address, WE_N and DQ enable come only from registered state plus addr, so they
  // settle together after each edge and WE_N rises while data and address are stable.
  assign in_phase  = (state == LO) || (state == HI);
  assign dq_oe     = op_write && in_phase;
  assign dq_out    = (state == HI) ? wr_data[31:16] : wr_data[15:0];
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_WE_N = !(dq_oe && (cnt != LAST));

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign ready = ((state == IDLE) && !mem_read && !mem_write) || (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_read || mem_write) begin
            state    <= LO;
            op_write <= mem_write;
          end
        end
        LO, HI: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= (state == LO) ? HI : DONE;
            if (!op_write) begin
              if (state == LO) read_data[15:0]  <= SRAM_DQ;
              else             read_data[31:16] <= SRAM_DQ;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
